// File: rtl/alu_sched.sv
// alu_sched: arbitrates two requesters onto one shared ALU and returns the result to the owner.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_sched #(
  parameter int WORD_SIZE = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [39:0]            req_cmd,
  input  logic [2*WORD_SIZE-1:0] req_in1,
  input  logic [2*WORD_SIZE-1:0] req_in2,
  output logic [1:0]             rsp_valid,
  output logic [WORD_SIZE-1:0]   rsp_res,
  output logic [1:0]             rsp_flags,
  output logic [WORD_SIZE-1:0]   alu_in1,
  output logic [WORD_SIZE-1:0]   alu_in2,
  output logic                   alu_carry_in,
  output logic [4:0]             alu_op_size,
  output logic [4:0]             alu_op_offset1,
  output logic [4:0]             alu_op_offset2,
  output logic [3:0]             alu_operation,
  output logic                   alu_start,
  input  logic [WORD_SIZE-1:0]   alu_res,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  input  logic                   alu_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, MWAIT, RESP} state_t;

  typedef struct packed {
    logic       carry_in;
    logic [4:0] op_offset2;
    logic [4:0] op_offset1;
    logic [4:0] op_size;
    logic [3:0] operation;
  } cmd_t;

  localparam logic [3:0] OP_MUL = 4'b1000;

  state_t               state_q;
  cmd_t                 cmd_q;
  logic [WORD_SIZE-1:0] in1_q;
  logic [WORD_SIZE-1:0] in2_q;
  logic                 owner_q;
  logic [1:0]           grant;
  logic                 accept;
  logic                 sel;
  cmd_t                 sel_cmd;

`ifdef ALU_SCHED_RR_EN
  logic last_q;  // requester served most recently

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end
`else
  always_comb begin
    grant = 2'b00;
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
  end
`endif

  // Ready is combinational so a request is taken in the same cycle the ALU frees up.
  assign req_ready = (rst && state_q == IDLE && alu_ready) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel       = req_ready[1];
  assign sel_cmd   = cmd_t'(sel ? req_cmd[39:20] : req_cmd[19:0]);

  assign alu_in1        = in1_q;
  assign alu_in2        = in2_q;
  assign alu_carry_in   = cmd_q.carry_in;
  assign alu_op_size    = cmd_q.op_size;
  assign alu_op_offset1 = cmd_q.op_offset1;
  assign alu_op_offset2 = cmd_q.op_offset2;
  assign alu_operation  = cmd_q.operation;

  // NOTE: every register here uses <= so all state updates see pre-edge values, avoiding ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the wide operand/result registers are reset too, so the ALU never sees stale data after reset.
      state_q   <= IDLE;
      cmd_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      owner_q   <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_res   <= '0;
      rsp_flags <= 2'b00;
      alu_start <= 1'b0;
`ifdef ALU_SCHED_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      rsp_valid <= 2'b00;
      alu_start <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_q     <= sel_cmd;
            in1_q     <= sel ? req_in1[2*WORD_SIZE-1:WORD_SIZE] : req_in1[WORD_SIZE-1:0];
            in2_q     <= sel ? req_in2[2*WORD_SIZE-1:WORD_SIZE] : req_in2[WORD_SIZE-1:0];
            owner_q   <= sel;
            alu_start <= (sel_cmd.operation == OP_MUL);
`ifdef ALU_SCHED_RR_EN
            last_q    <= sel;
`endif
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (cmd_q.operation == OP_MUL) begin
            state_q <= MWAIT;
          end else begin
            rsp_res   <= alu_res;
            rsp_flags <= {alu_carry, alu_zero};
            rsp_valid <= {owner_q, ~owner_q};
            state_q   <= RESP;
          end
        end
        MWAIT: begin
          if (alu_ready) begin
            rsp_res   <= alu_res;
            rsp_flags <= {alu_carry, alu_zero};
            rsp_valid <= {owner_q, ~owner_q};
            state_q   <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
